// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared run-state and wrap-mode encodings for the PC tracer.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_WRAP_STOP      = 0;
    localparam int c_WRAP_OVERWRITE = 1;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : PC trace storage: push/pop FIFO with drop or overwrite on full.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
    import trace_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = c_WRAP_STOP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_data,
    input  logic                   pop,
    output logic [ADDR_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_P_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_C_ONE = (c_PTR_W+1)'(1);

    logic [ADDR_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic [ADDR_W-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic               r_overflow;

    logic w_full;
    logic w_do_pop;
    logic w_evict;
    logic w_write;
    logic w_grow;

    assign w_full   = (r_count == c_FULL);
    assign w_do_pop = pop && (r_count != '0);
    // A pop in the same cycle frees a slot, so a full-buffer push is not an overflow then.
    assign w_evict  = push && w_full && !w_do_pop;
    assign w_write  = push && (!w_evict || (WRAP_MODE == c_WRAP_OVERWRITE));
    assign w_grow   = w_write && !w_evict;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= w_do_pop;
            if (w_do_pop) begin
                r_rd_data <= r_mem[r_rptr];
            end
            if (w_write) begin
                r_wptr <= r_wptr + c_P_ONE;
            end
            // Overwrite mode discards the oldest entry by stepping the read side too.
            if (w_do_pop || (w_write && w_evict)) begin
                r_rptr <= r_rptr + c_P_ONE;
            end
            if (w_grow && !w_do_pop) begin
                r_count <= r_count + c_C_ONE;
            end else if (!w_grow && w_do_pop) begin
                r_count <= r_count - c_C_ONE;
            end
            if (w_evict) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pc_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pc_trace_monitor
// Description : Captures changing CPU PCs per run; stops on stall or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_trace_monitor
    import trace_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CYC_W       = 32,
    parameter int STALL_LIMIT = 8,
    parameter int WRAP_MODE   = c_WRAP_STOP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      pc,
    input  logic                   pc_valid,
    input  logic [CYC_W-1:0]       cycle_limit,
    input  logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   halted,
    output logic                   timeout,
    output logic                   busy,
    output logic                   done
);

    localparam int                   c_STALL_W   = $clog2(STALL_LIMIT) + 1;
    localparam logic [c_STALL_W-1:0] c_STALL_HIT = c_STALL_W'(STALL_LIMIT - 1);
    localparam logic [c_STALL_W-1:0] c_S_ONE     = c_STALL_W'(1);
    localparam logic [CYC_W-1:0]     c_CYC_ONE   = CYC_W'(1);

    state_t               r_state;
    logic [CYC_W-1:0]     r_cycle_cnt;
    logic [CYC_W-1:0]     r_limit;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic [ADDR_W-1:0]    r_last_pc;
    logic                 r_last_valid;
    logic                 r_halted;
    logic                 r_timeout;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_run;
    logic                 w_clear;
    logic                 w_same;
    logic                 w_push;
    logic [c_STALL_W-1:0] w_stall_nxt;
    logic                 w_halt_hit;
    logic                 w_tmo_hit;

    assign w_run       = (r_state == ST_RUN);
    assign w_clear     = start && !w_run;
    assign w_same      = pc_valid && r_last_valid && (pc == r_last_pc);
    assign w_push      = w_run && pc_valid && !w_same;
    assign w_stall_nxt = r_stall_cnt + c_S_ONE;
    assign w_halt_hit  = w_run && w_same && (w_stall_nxt == c_STALL_HIT);
    // A zero limit would never match limit-1, so it expires on the first run cycle.
    assign w_tmo_hit   = w_run && ((r_limit == '0) || (r_cycle_cnt == r_limit - c_CYC_ONE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cycle_cnt  <= '0;
            r_limit      <= '0;
            r_stall_cnt  <= '0;
            r_last_pc    <= '0;
            r_last_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b1;
                        r_limit      <= cycle_limit;
                        r_cycle_cnt  <= '0;
                        r_stall_cnt  <= '0;
                        r_last_valid <= 1'b0;
                        r_halted     <= 1'b0;
                        r_timeout    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + c_CYC_ONE;
                    if (w_push) begin
                        r_last_pc    <= pc;
                        r_last_valid <= 1'b1;
                        r_stall_cnt  <= '0;
                    end else if (w_same) begin
                        r_stall_cnt <= w_stall_nxt;
                    end
                    if (w_halt_hit) begin
                        r_halted <= 1'b1;
                    end
                    if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                    end
                    if (w_halt_hit || w_tmo_hit) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    trace_fifo #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .push      (w_push),
        .push_data (pc),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .overflow  (overflow)
    );

    assign halted  = r_halted;
    assign timeout = r_timeout;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_trace_monitor
// Description : Scoreboard bench for pc_trace_monitor, stop and overwrite modes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_trace_monitor;

    localparam int AW   = 32;
    localparam int DEP  = 16;
    localparam int CW   = 32;
    localparam int CNTW = $clog2(DEP) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            start;
    logic [AW-1:0]   pc;
    logic            pc_valid;
    logic [CW-1:0]   cycle_limit;
    logic            rd_en;

    logic [AW-1:0]   rd_data0, rd_data1;
    logic            rd_valid0, rd_valid1;
    logic [CNTW-1:0] count0, count1;
    logic            overflow0, overflow1;
    logic            halted0, halted1;
    logic            timeout0, timeout1;
    logic            busy0, busy1;
    logic            done0, done1;

    pc_trace_monitor #(
        .ADDR_W(AW), .DEPTH(DEP), .CYC_W(CW), .STALL_LIMIT(8), .WRAP_MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
        .cycle_limit(cycle_limit), .rd_en(rd_en), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .count(count0), .overflow(overflow0),
        .halted(halted0), .timeout(timeout0), .busy(busy0), .done(done0)
    );

    pc_trace_monitor #(
        .ADDR_W(AW), .DEPTH(DEP), .CYC_W(CW), .STALL_LIMIT(8), .WRAP_MODE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
        .cycle_limit(cycle_limit), .rd_en(rd_en), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .count(count1), .overflow(overflow1),
        .halted(halted1), .timeout(timeout1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt0 = 0;
    logic [AW-1:0] q0[$];
    logic [AW-1:0] q1[$];

    always @(negedge clk) begin
        if (done0) done_cnt0 <= done_cnt0 + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rd_valid0) begin
                if (q0.size() == 0) chk("rd0_unexpected", rd_valid0, 64'd0);
                else                chk("rd0_data", rd_data0, q0.pop_front());
            end
            if (rd_valid1) begin
                if (q1.size() == 0) chk("rd1_unexpected", rd_valid1, 64'd0);
                else                chk("rd1_data", rd_data1, q1.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dorst();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic start_run(input logic [CW-1:0] lim);
        start       = 1'b1;
        cycle_limit = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic push_pc(input logic [AW-1:0] p);
        pc       = p;
        pc_valid = 1'b1;
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        int d0;
        fork
            monitor();
        join_none
        reset = 1'b0; start = 1'b0; pc = '0; pc_valid = 1'b0; rd_en = 1'b0; cycle_limit = '0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        chk("rst_count", count0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_flags", {overflow0, halted0, timeout0, done0}, 0);
        chk("rst_rd", {rd_valid0, rd_data0}, 0);

        // Stop-on-full capture and timeout after 100 cycles
        d0 = done_cnt0;
        start_run(100);
        for (int i = 0; i < 100; i++) begin
            push_pc(AW'(4 * i));
            if (i == 15) begin
                chk("a_count_full", count0, 16);
                chk("a_ovf_before", overflow0, 0);
            end
            if (i == 16) chk("a_ovf_17th", overflow0, 1);
            if (i == 98) chk("a_busy_tmo_early", {busy0, timeout0}, 2'b10);
        end
        pc_valid = 1'b0;
        chk("a_timeout", timeout0, 1);
        chk("a_busy_done", busy0, 0);
        chk("a_halted", halted0, 0);
        chk("a_wrap_count", count1, 16);
        tick();
        tick();
        chk("a_done_pulses", done_cnt0 - d0, 1);
        for (int k = 0; k < 16; k++) begin
            q0.push_back(AW'(4 * k));
            q1.push_back(AW'(4 * (84 + k)));
            pop_one();
        end
        tick();
        chk("a_drained", count0, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("a_empty_rd", rd_valid0, 0);

        // Overwrite mode keeps the newest 16 of 20 PCs
        dorst();
        start_run(1000);
        for (int i = 0; i < 20; i++) push_pc(AW'(4 * i));
        pc_valid = 1'b0;
        chk("b_count1", count1, 16);
        chk("b_ovf1", overflow1, 1);
        chk("b_count0", count0, 16);
        for (int k = 0; k < 16; k++) begin
            q0.push_back(AW'(4 * k));
            q1.push_back(AW'(32'h10 + 4 * k));
            pop_one();
        end
        tick();

        // Stall detection: 0x108 held for 8 valid cycles
        dorst();
        start_run(1000);
        push_pc(32'h100);
        push_pc(32'h104);
        for (int j = 0; j < 8; j++) begin
            push_pc(32'h108);
            if (j == 6) chk("c_not_yet", {halted0, busy0}, 2'b01);
        end
        pc_valid = 1'b0;
        chk("c_halted", halted0, 1);
        chk("c_timeout", timeout0, 0);
        chk("c_busy", busy0, 0);
        chk("c_count", count0, 3);
        chk("c_halted1", halted1, 1);
        q0.push_back(32'h100); q0.push_back(32'h104); q0.push_back(32'h108);
        q1.push_back(32'h100); q1.push_back(32'h104); q1.push_back(32'h108);
        for (int k = 0; k < 3; k++) pop_one();
        tick();

        // Push and pop on a full buffer in the same cycle
        dorst();
        start_run(1000);
        for (int i = 0; i < 16; i++) push_pc(AW'(32'h200 + 4 * i));
        pc    = 32'h240;
        rd_en = 1'b1;
        q0.push_back(32'h200);
        q1.push_back(32'h200);
        tick();
        rd_en    = 1'b0;
        pc_valid = 1'b0;
        chk("d_count0", count0, 16);
        chk("d_ovf0", overflow0, 0);
        chk("d_count1", count1, 16);
        chk("d_ovf1", overflow1, 0);
        for (int k = 0; k < 16; k++) begin
            q0.push_back(AW'(32'h204 + 4 * k));
            q1.push_back(AW'(32'h204 + 4 * k));
            pop_one();
        end
        tick();

        // Reset in the middle of a run
        dorst();
        start_run(1000);
        for (int i = 0; i < 5; i++) push_pc(AW'(32'h80 + 4 * i));
        pc_valid = 1'b0;
        chk("e_pre_count", count0, 5);
        dorst();
        chk("e_count", count0, 0);
        chk("e_busy", busy0, 0);
        chk("e_flags", {overflow0, halted0, timeout0, done0, rd_valid0}, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("e_rd_valid", rd_valid0, 0);

        // Halt and timeout on the same cycle
        dorst();
        start_run(8);
        for (int j = 0; j < 8; j++) begin
            push_pc(32'h300);
            if (j == 6) chk("f_not_yet", {halted0, timeout0}, 0);
        end
        pc_valid = 1'b0;
        chk("f_both", {halted0, timeout0, busy0}, 3'b110);
        q0.push_back(32'h300);
        q1.push_back(32'h300);
        pop_one();
        tick();

        // Zero limit, restart from DONE, start ignored while running
        dorst();
        start_run(0);
        tick();
        chk("g_tmo0", {timeout0, busy0, halted0}, 3'b100);
        start_run(3);
        chk("g_restart", {timeout0, busy0}, 2'b01);
        pc       = 32'h40;
        pc_valid = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        pc_valid = 1'b0;
        tick();
        chk("g_start_ignored", count0, 1);
        chk("g_still_busy", busy0, 1);
        tick();
        chk("g_tmo3", {timeout0, busy0}, 2'b10);
        q0.push_back(32'h40);
        q1.push_back(32'h40);
        pop_one();
        tick();
        tick();

        chk("sb_q0_left", q0.size(), 0);
        chk("sb_q1_left", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_trace_monitor.md
PC_TRACE_MONITOR -- requirements
Module: pc_trace_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning trace buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter CYC_W, default 32, meaning cycle-counter and limit width.
REQ-004 SHALL have parameter STALL_LIMIT, default 8, meaning consecutive identical valid PCs that declare a halt.
REQ-005 SHALL have parameter WRAP_MODE, default 0, meaning 0 = stop capture when full, 1 = overwrite oldest.
REQ-006 SHALL have ports: clk  in  1  clock; all logic on its rising edge.
REQ-007 SHALL have: reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have: start  in  1  one-cycle pulse arming a run.
REQ-009 SHALL have: pc  in  ADDR_W  CPU program counter.
REQ-010 SHALL have: pc_valid  in  1  pc qualifies this cycle.
REQ-011 SHALL have: cycle_limit  in  CYC_W  run timeout in clk cycles, sampled on start.
REQ-012 SHALL have: rd_en  in  1  pop oldest trace entry.
REQ-013 SHALL have: rd_data  out  ADDR_W  popped PC; rd_valid  out  1  rd_data valid.
REQ-014 SHALL have: count  out  $clog2(DEPTH)+1  entries held.
REQ-015 SHALL have: overflow  out  1  sticky, PC dropped or overwritten.
REQ-016 SHALL have: halted, timeout, busy, done  out  1 each  run status.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE; DONE -> RUN on start; start ignored in RUN.
REQ-018 start in IDLE/DONE SHALL clear buffer, count, overflow, halted, timeout, cycle counter, stall counter, last_pc valid flag; latch cycle_limit; enter RUN next cycle.
REQ-019 In RUN the cycle counter SHALL increment every cycle; when it equals latched limit-1, timeout SHALL set and FSM SHALL enter DONE next cycle; limit 0 SHALL time out after 1 cycle.
REQ-020 In RUN, pc_valid with pc != last_pc (or first valid of run) SHALL push pc, update last_pc, clear stall counter.
REQ-021 pc_valid with pc == last_pc SHALL increment stall counter without pushing; reaching STALL_LIMIT-1 SHALL set halted and enter DONE next cycle.
REQ-022 Halt and timeout on the same cycle SHALL set both flags.
REQ-023 Full with push: WRAP_MODE=0 SHALL drop PC; WRAP_MODE=1 SHALL overwrite oldest (advance read pointer); both SHALL set overflow.
REQ-024 rd_en with count>0 SHALL pop in any state; rd_data/rd_valid SHALL be registered, valid exactly the next cycle; rd_en with count==0 SHALL be ignored, rd_valid 0.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; with full buffer pop wins slot and push succeeds without overflow.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 busy SHALL be 1 in RUN only; done SHALL be a one-cycle pulse on RUN->DONE.

Reset
REQ-028 reset low at a clk edge SHALL force IDLE, pointers and count 0, all status outputs 0, rd_data 0, rd_valid 0, regardless of state, including mid-run.
REQ-029 Buffer storage SHALL need no reset.

Structure
REQ-030 FSM state enum and WRAP_MODE encodings SHALL live in shared package trace_pkg.
REQ-031 Storage and pointers SHALL be one sub-module trace_fifo (push, pop, overwrite, count); FSM, counters, comparators in top.

Verification
REQ-032 start, limit 100, pc 0,4,8,... each cycle -> 16 entries, overflow set at 17th PC (WRAP_MODE=0), timeout after 100 cycles, done pulse once.
REQ-033 WRAP_MODE=1, 20 distinct PCs 0x0..0x4C -> count 16, pops return 0x10..0x4C in order, overflow 1.
REQ-034 pc 0x100,0x104 then 0x108 held valid 8 cycles -> 3 entries, halted 1, timeout 0, DONE.
REQ-035 Full buffer, push and rd_en same cycle -> count stays 16, oldest returned next cycle, overflow 0.
REQ-036 reset low mid-RUN with 5 entries -> next cycle count 0, busy 0, all flags 0; rd_en then yields rd_valid 0.
REQ-037 halt and timeout coincident (limit 8, constant pc from cycle 0) -> halted and timeout both 1.
